// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline control.
// Holds the opcode map, the forwarding-select encodings and the hazard FSM state type.
// Also holds the operand-usage decode that the hazard logic and the decoder agree on.
package cpu_pkg;

   // Opcode map of the 4-bit instruction field
   localparam logic [3:0] LDA_imm    = 4'b0000;
   localparam logic [3:0] CAL_add    = 4'b0001;
   localparam logic [3:0] CAL_sub    = 4'b0010;
   localparam logic [3:0] CAL_mul    = 4'b0011;
   localparam logic [3:0] CAL_and    = 4'b0100;
   localparam logic [3:0] CAL_or     = 4'b0101;
   localparam logic [3:0] IMM_add    = 4'b0110;
   localparam logic [3:0] IMM_sub    = 4'b0111;
   localparam logic [3:0] IMM_mul    = 4'b1000;
   localparam logic [3:0] LDA_reg    = 4'b1001;
   localparam logic [3:0] BAF_regsub = 4'b1010;

   // EX operand source selects
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_EXM = 2'b10;
   localparam logic [1:0] FWD_MWB = 2'b01;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MUL_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   // Register-register forms read a second source
   function automatic logic rt_used(input logic [3:0] op);
      return (op == CAL_add) || (op == CAL_sub) || (op == CAL_mul) ||
             (op == CAL_and) || (op == CAL_or)  || (op == BAF_regsub);
   endfunction

   // Only the immediate load has no register source
   function automatic logic rs_used(input logic [3:0] op);
      return op != LDA_imm;
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding select for the ID instruction's two sources.
// Purely combinational; the selects are captured by the ID/EX register.
// The younger result (EX/MEM) wins over MEM/WB when both target the same register.
module fwd_unit
   import cpu_pkg::*;
#(
   parameter int REG_AW = 4
) (
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   input  logic              exm_regwrite,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic              mwb_regwrite,
   input  logic [REG_AW-1:0] mwb_rd,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   // Pick the most recent in-flight producer of each source, else the regfile
   always_comb begin
      fwd_a = FWD_REG;
      fwd_b = FWD_REG;
      if (exm_regwrite && (exm_rd == rs))      fwd_a = FWD_EXM;
      else if (mwb_regwrite && (mwb_rd == rs)) fwd_a = FWD_MWB;
      if (exm_regwrite && (exm_rd == rt))      fwd_b = FWD_EXM;
      else if (mwb_regwrite && (mwb_rd == rt)) fwd_b = FWD_MWB;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 4-stage pipeline: enables, flush/bubble and forwarding selects.
// Stall decisions are combinational in the cycle the hazard is seen; FSM state and o_halted are registered.
// Priority: branch flush > multiply occupancy > load-use > debug halt entry.
module pipeline_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_AW  = 4,
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        i_opcode_id,
   input  logic [REG_AW-1:0] i_rs_id,
   input  logic [REG_AW-1:0] i_rt_id,
   input  logic              i_idex_memtoreg,
   input  logic              i_idex_mul,
   input  logic [REG_AW-1:0] i_idex_rd,
   input  logic              i_exm_regwrite,
   input  logic [REG_AW-1:0] i_exm_rd,
   input  logic              i_mwb_regwrite,
   input  logic [REG_AW-1:0] i_mwb_rd,
   input  logic              i_branch_taken,
   input  logic              i_halt_req,
   output logic              o_pc_en,
   output logic              o_ifid_en,
   output logic              o_ifid_flush,
   output logic              o_idex_bubble,
   output logic [1:0]        o_fwd_a,
   output logic [1:0]        o_fwd_b,
   output logic              o_halted
);

   // MUL_WAIT lasts MUL_LAT-2 cycles after the RUN cycle that detects the multiply
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_LAT > 2) ? (MUL_LAT - 2) : 0);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             halted_q;
   logic             halt_pend_q;
   logic             mul_release_q;
   logic             load_use;
   logic             mul_occ;
   logic [1:0]       fwd_a_raw;
   logic [1:0]       fwd_b_raw;

   fwd_unit #(.REG_AW(REG_AW)) u_fwd (
      .rs           (i_rs_id),
      .rt           (i_rt_id),
      .exm_regwrite (i_exm_regwrite),
      .exm_rd       (i_exm_rd),
      .mwb_regwrite (i_mwb_regwrite),
      .mwb_rd       (i_mwb_rd),
      .fwd_a        (fwd_a_raw),
      .fwd_b        (fwd_b_raw)
   );

   assign load_use = i_idex_memtoreg &&
                     ((rs_used(i_opcode_id) && (i_idex_rd == i_rs_id)) ||
                      (rt_used(i_opcode_id) && (i_idex_rd == i_rt_id)));

   // The multiply is still in ID/EX for one cycle after its freeze ends; mul_release_q
   // lets it advance instead of retriggering the occupancy stall.
   assign mul_occ = i_idex_mul && (MUL_LAT > 1) && !mul_release_q;

   assign o_fwd_a  = reset ? FWD_REG : fwd_a_raw;
   assign o_fwd_b  = reset ? FWD_REG : fwd_b_raw;
   assign o_halted = halted_q;

   // Sequencing FSM: multiply occupancy countdown, deferred and level halt, registered halt flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         cnt_q         <= '0;
         halted_q      <= 1'b0;
         halt_pend_q   <= 1'b0;
         mul_release_q <= 1'b0;
      end else begin
         mul_release_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (i_branch_taken) begin
                  state_q <= RUN;
               end else if (mul_occ) begin
                  if (i_halt_req) halt_pend_q <= 1'b1;
                  if (MUL_LAT > 2) begin
                     state_q <= MUL_WAIT;
                     cnt_q   <= CNT_LOAD;
                  end else begin
                     mul_release_q <= 1'b1;
                  end
               end else if (load_use) begin
                  state_q <= RUN;
               end else if (i_halt_req || halt_pend_q) begin
                  state_q     <= HALT;
                  halted_q    <= 1'b1;
                  halt_pend_q <= 1'b0;
               end
            end
            MUL_WAIT: begin
               if (i_halt_req) halt_pend_q <= 1'b1;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q <= CNT_W'(1)) begin
                  state_q       <= RUN;
                  mul_release_q <= 1'b1;
               end
            end
            HALT: begin
               if (!i_halt_req) begin
                  state_q  <= RUN;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q <= RUN;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Pipeline-register controls for the current cycle; reset forces NOPs into IF/ID and ID/EX
   always_comb begin
      o_pc_en       = 1'b1;
      o_ifid_en     = 1'b1;
      o_ifid_flush  = 1'b0;
      o_idex_bubble = 1'b0;
      if (reset) begin
         o_pc_en       = 1'b0;
         o_ifid_en     = 1'b0;
         o_ifid_flush  = 1'b1;
         o_idex_bubble = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (i_branch_taken) begin
                  o_ifid_flush  = 1'b1;
                  o_idex_bubble = 1'b1;
               end else if (mul_occ) begin
                  o_pc_en   = 1'b0;
                  o_ifid_en = 1'b0;
               end else if (load_use) begin
                  o_pc_en       = 1'b0;
                  o_ifid_en     = 1'b0;
                  o_idex_bubble = 1'b1;
               end
            end
            MUL_WAIT: begin
               o_pc_en   = 1'b0;
               o_ifid_en = 1'b0;
            end
            default: begin
               o_pc_en       = 1'b0;
               o_ifid_en     = 1'b0;
               o_idex_bubble = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl at default parameters (MUL_LAT=3).
// Inputs change just after each falling edge; outputs are checked 1ns later.
// Control outputs are compared as {pc_en, ifid_en, ifid_flush, idex_bubble, halted}.
module tb_pipeline_hazard_ctrl;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] i_opcode_id;
   logic [3:0] i_rs_id, i_rt_id, i_idex_rd, i_exm_rd, i_mwb_rd;
   logic       i_idex_memtoreg, i_idex_mul, i_exm_regwrite, i_mwb_regwrite;
   logic       i_branch_taken, i_halt_req;
   logic       o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_halted;
   logic [1:0] o_fwd_a, o_fwd_b;
   logic [4:0] ctl;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [4:0] C_RST  = 5'b00110;
   localparam logic [4:0] C_NORM = 5'b11000;
   localparam logic [4:0] C_LU   = 5'b00010;
   localparam logic [4:0] C_MUL  = 5'b00000;
   localparam logic [4:0] C_BR   = 5'b11110;
   localparam logic [4:0] C_HALT = 5'b00011;

   assign ctl = {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_halted};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .i_opcode_id     (i_opcode_id),
      .i_rs_id         (i_rs_id),
      .i_rt_id         (i_rt_id),
      .i_idex_memtoreg (i_idex_memtoreg),
      .i_idex_mul      (i_idex_mul),
      .i_idex_rd       (i_idex_rd),
      .i_exm_regwrite  (i_exm_regwrite),
      .i_exm_rd        (i_exm_rd),
      .i_mwb_regwrite  (i_mwb_regwrite),
      .i_mwb_rd        (i_mwb_rd),
      .i_branch_taken  (i_branch_taken),
      .i_halt_req      (i_halt_req),
      .o_pc_en         (o_pc_en),
      .o_ifid_en       (o_ifid_en),
      .o_ifid_flush    (o_ifid_flush),
      .o_idex_bubble   (o_idex_bubble),
      .o_fwd_a         (o_fwd_a),
      .o_fwd_b         (o_fwd_b),
      .o_halted        (o_halted)
   );

   task automatic idle();
      i_opcode_id = CAL_add; i_rs_id = 4'd0; i_rt_id = 4'd0;
      i_idex_memtoreg = 1'b0; i_idex_mul = 1'b0; i_idex_rd = 4'd0;
      i_exm_regwrite = 1'b0; i_exm_rd = 4'd0;
      i_mwb_regwrite = 1'b0; i_mwb_rd = 4'd0;
      i_branch_taken = 1'b0; i_halt_req = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      i_rs_id = 4'd2; i_exm_regwrite = 1'b1; i_exm_rd = 4'd2;
      @(negedge clk); #1;
      n_cmp++; if (ctl !== C_RST) begin n_err++; $display("FAIL rst_ctl: got %b want %b", ctl, C_RST); end
      n_cmp++; if (o_fwd_a !== 2'b00) begin n_err++; $display("FAIL rst_fwd_a: got %b want 00", o_fwd_a); end
      @(negedge clk); reset = 1'b0; idle(); #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL rst_release: got %b want %b", ctl, C_NORM); end
   endtask

   task automatic test_load_use();
      // LDA r3 in ID/EX, CAL_add r4,r3,r1 in ID
      @(negedge clk); idle();
      i_opcode_id = CAL_add; i_rs_id = 4'd3; i_rt_id = 4'd1;
      i_idex_memtoreg = 1'b1; i_idex_rd = 4'd3; #1;
      n_cmp++; if (ctl !== C_LU) begin n_err++; $display("FAIL lu_stall: got %b want %b", ctl, C_LU); end
      // bubble now in EX/MEM, LDA result reaches MEM/WB
      @(negedge clk); idle();
      i_opcode_id = CAL_add; i_rs_id = 4'd3; i_rt_id = 4'd1;
      i_mwb_regwrite = 1'b1; i_mwb_rd = 4'd3; #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL lu_release: got %b want %b", ctl, C_NORM); end
      n_cmp++; if ({o_fwd_a, o_fwd_b} !== 4'b0100) begin n_err++; $display("FAIL lu_fwd: got %b want 0100", {o_fwd_a, o_fwd_b}); end
      // rt matches but IMM_add does not read rt: no stall
      @(negedge clk); idle();
      i_opcode_id = IMM_add; i_rs_id = 4'd5; i_rt_id = 4'd3;
      i_idex_memtoreg = 1'b1; i_idex_rd = 4'd3; #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL lu_rt_unused: got %b want %b", ctl, C_NORM); end
      // rt matches and CAL_sub reads rt: stall
      @(negedge clk); i_opcode_id = CAL_sub; #1;
      n_cmp++; if (ctl !== C_LU) begin n_err++; $display("FAIL lu_rt_used: got %b want %b", ctl, C_LU); end
      // LDA_imm reads no register even though rs field matches
      @(negedge clk); idle();
      i_opcode_id = LDA_imm; i_rs_id = 4'd3; i_rt_id = 4'd3;
      i_idex_memtoreg = 1'b1; i_idex_rd = 4'd3; #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL lu_lda_imm: got %b want %b", ctl, C_NORM); end
   endtask

   task automatic test_forwarding();
      @(negedge clk); idle();
      i_opcode_id = CAL_sub; i_rs_id = 4'd2; i_rt_id = 4'd2;
      i_exm_regwrite = 1'b1; i_exm_rd = 4'd2; #1;
      n_cmp++; if ({o_fwd_a, o_fwd_b, ctl} !== {4'b1010, C_NORM}) begin n_err++; $display("FAIL fwd_exm: got %b want %b", {o_fwd_a, o_fwd_b, ctl}, {4'b1010, C_NORM}); end
      @(negedge clk); i_rt_id = 4'd7; i_mwb_regwrite = 1'b1; i_mwb_rd = 4'd2; #1;
      n_cmp++; if ({o_fwd_a, o_fwd_b} !== 4'b1000) begin n_err++; $display("FAIL fwd_priority: got %b want 1000", {o_fwd_a, o_fwd_b}); end
      @(negedge clk); i_exm_regwrite = 1'b0; i_rt_id = 4'd2; #1;
      n_cmp++; if ({o_fwd_a, o_fwd_b} !== 4'b0101) begin n_err++; $display("FAIL fwd_mwb: got %b want 0101", {o_fwd_a, o_fwd_b}); end
      @(negedge clk); i_mwb_regwrite = 1'b0; i_exm_rd = 4'd2; #1;
      n_cmp++; if ({o_fwd_a, o_fwd_b} !== 4'b0000) begin n_err++; $display("FAIL fwd_nowrite: got %b want 0000", {o_fwd_a, o_fwd_b}); end
   endtask

   task automatic test_mul();
      @(negedge clk); idle(); i_idex_mul = 1'b1; #1;
      n_cmp++; if (ctl !== C_MUL) begin n_err++; $display("FAIL mul_c0: got %b want %b", ctl, C_MUL); end
      @(negedge clk); #1;
      n_cmp++; if (ctl !== C_MUL) begin n_err++; $display("FAIL mul_c1: got %b want %b", ctl, C_MUL); end
      @(negedge clk); #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL mul_done: got %b want %b", ctl, C_NORM); end
      @(negedge clk); idle(); #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL mul_after: got %b want %b", ctl, C_NORM); end
   endtask

   task automatic test_branch();
      @(negedge clk); idle();
      i_opcode_id = BAF_regsub; i_rs_id = 4'd6; i_rt_id = 4'd1;
      i_idex_memtoreg = 1'b1; i_idex_rd = 4'd6; i_branch_taken = 1'b1; #1;
      n_cmp++; if (ctl !== C_BR) begin n_err++; $display("FAIL br_over_lu: got %b want %b", ctl, C_BR); end
      @(negedge clk); idle(); #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL br_after: got %b want %b", ctl, C_NORM); end
   endtask

   task automatic test_halt();
      // halt pulse while the multiply is in MUL_WAIT
      @(negedge clk); idle(); i_idex_mul = 1'b1; #1;
      n_cmp++; if (ctl !== C_MUL) begin n_err++; $display("FAIL hm_mul0: got %b want %b", ctl, C_MUL); end
      @(negedge clk); i_halt_req = 1'b1; #1;
      n_cmp++; if (ctl !== C_MUL) begin n_err++; $display("FAIL hm_mul1: got %b want %b", ctl, C_MUL); end
      @(negedge clk); i_halt_req = 1'b0; #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL hm_mul_end: got %b want %b", ctl, C_NORM); end
      @(negedge clk); idle(); #1;
      n_cmp++; if (ctl !== C_HALT) begin n_err++; $display("FAIL hm_halted: got %b want %b", ctl, C_HALT); end
      @(negedge clk); #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL hm_resume: got %b want %b", ctl, C_NORM); end
      // level halt, then asynchronous reset in HALT
      @(negedge clk); i_halt_req = 1'b1; #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL hl_entry: got %b want %b", ctl, C_NORM); end
      @(negedge clk); #1;
      n_cmp++; if (ctl !== C_HALT) begin n_err++; $display("FAIL hl_halt: got %b want %b", ctl, C_HALT); end
      #2 reset = 1'b1; #1;
      n_cmp++; if (ctl !== C_RST) begin n_err++; $display("FAIL hl_async_rst: got %b want %b", ctl, C_RST); end
      @(negedge clk); reset = 1'b0; i_halt_req = 1'b0; #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL hl_rst_run: got %b want %b", ctl, C_NORM); end
      // asynchronous reset during MUL_WAIT clears the countdown
      @(negedge clk); i_idex_mul = 1'b1; #1;
      @(negedge clk); #1;
      n_cmp++; if (ctl !== C_MUL) begin n_err++; $display("FAIL mr_wait: got %b want %b", ctl, C_MUL); end
      #2 reset = 1'b1; #1;
      n_cmp++; if (ctl !== C_RST) begin n_err++; $display("FAIL mr_async_rst: got %b want %b", ctl, C_RST); end
      @(negedge clk); reset = 1'b0; idle(); #1;
      n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL mr_run: got %b want %b", ctl, C_NORM); end
   endtask

   initial begin
      idle();
      test_reset();
      test_load_use();
      test_forwarding();
      test_mul();
      test_branch();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
